// File: rtl/OoO_pkg.sv
// Shared front-end types: the fetch-queue entry and the default queue depth.
package OoO_pkg;

    localparam int unsigned InstrQueueDepth = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is_rv16;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Dual-push, single-pop circular FIFO of fetch entries with flush and a free-entry count.
module instr_queue
    import OoO_pkg::*;
#(
    parameter int unsigned QueueDepth = InstrQueueDepth,
    localparam int unsigned IdxW = $clog2(QueueDepth),
    localparam int unsigned PtrW = IdxW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push0_i,
    input  fetch_entry_t    push0_data_i,
    input  logic            push1_i,
    input  fetch_entry_t    push1_data_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic            empty_o,
    output logic [PtrW-1:0] free_o
);

    fetch_entry_t    mem [QueueDepth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] wr_ptr1;
    logic [PtrW-1:0] count;

    assign count   = wr_ptr - rd_ptr;
    assign empty_o = (count == '0);
    assign free_o  = PtrW'(QueueDepth) - count;
    assign wr_ptr1 = wr_ptr + PtrW'(1);
    assign head_o  = mem[rd_ptr[IdxW-1:0]];

    // push1 is only ever asserted together with push0, so it always lands one slot later
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < QueueDepth; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push0_i) begin
                mem[wr_ptr[IdxW-1:0]] <= push0_data_i;
            end
            if (push1_i) begin
                mem[wr_ptr1[IdxW-1:0]] <= push1_data_i;
            end
            wr_ptr <= wr_ptr + PtrW'(push0_i) + PtrW'(push1_i);
            if (pop_i && !empty_o) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_realigner.sv
// Splits aligned 32-bit fetch words into individual RV16/RV32 instructions, carrying
// the lower half of a word-straddling instruction in a halfword buffer.
module instr_realigner
    import OoO_pkg::*;
#(
    parameter int unsigned QueueDepth = InstrQueueDepth
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_addr_i,
    input  logic [31:0] fetch_data_i,
    input  logic        fetch_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_pc_o,
    output logic [31:0] instr_o,
    output logic        is_rv16_o,
    output logic        fetch_err_o
);

    localparam int unsigned PtrW = $clog2(QueueDepth) + 1;

    logic            hb_valid, hb_valid_n;
    logic [15:0]     hb_data, hb_data_n;
    logic [31:0]     hb_pc, hb_pc_n;
    logic            accept, proc_u, v0, v1, empty;
    logic [PtrW-1:0] free;
    logic [31:0]     word_addr;
    logic [15:0]     lo, up;
    fetch_entry_t    e0, e1, u_ent, head;

    assign fetch_ready_o = (free >= PtrW'(2)) && !flush_i;
    assign accept        = fetch_valid_i && fetch_ready_o;
    assign word_addr     = {fetch_addr_i[31:2], 2'b00};
    assign lo            = fetch_data_i[15:0];
    assign up            = fetch_data_i[31:16];

    always_comb begin
        e0         = '0;
        e1         = '0;
        u_ent      = '0;
        v0         = 1'b0;
        v1         = 1'b0;
        proc_u     = 1'b0;
        hb_valid_n = hb_valid;
        hb_data_n  = hb_data;
        hb_pc_n    = hb_pc;
        if (accept) begin
            if (fetch_err_i) begin
                e0         = '{pc: hb_valid ? hb_pc : fetch_addr_i, instr: '0, is_rv16: 1'b0, err: 1'b1};
                v0         = 1'b1;
                hb_valid_n = 1'b0;
            end else begin
                proc_u = 1'b1;
                if (hb_valid) begin
                    e0         = '{pc: hb_pc, instr: {lo, hb_data}, is_rv16: 1'b0, err: 1'b0};
                    v0         = 1'b1;
                    hb_valid_n = 1'b0;
                end else if (!fetch_addr_i[1]) begin
                    v0 = 1'b1;
                    if (lo[1:0] != 2'b11) begin
                        e0 = '{pc: word_addr, instr: {16'h0000, lo}, is_rv16: 1'b1, err: 1'b0};
                    end else begin
                        e0     = '{pc: word_addr, instr: fetch_data_i, is_rv16: 1'b0, err: 1'b0};
                        proc_u = 1'b0;
                    end
                end
                // Upper half goes into whichever push slot is still free, keeping address order
                if (proc_u) begin
                    if (up[1:0] != 2'b11) begin
                        u_ent = '{pc: word_addr + 32'd2, instr: {16'h0000, up}, is_rv16: 1'b1, err: 1'b0};
                        if (v0) begin
                            e1 = u_ent;
                            v1 = 1'b1;
                        end else begin
                            e0 = u_ent;
                            v0 = 1'b1;
                        end
                    end else begin
                        hb_valid_n = 1'b1;
                        hb_data_n  = up;
                        hb_pc_n    = word_addr + 32'd2;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hb_valid <= 1'b0;
            hb_data  <= '0;
            hb_pc    <= '0;
        end else if (flush_i) begin
            hb_valid <= 1'b0;
        end else begin
            hb_valid <= hb_valid_n;
            hb_data  <= hb_data_n;
            hb_pc    <= hb_pc_n;
        end
    end

    instr_queue #(
        .QueueDepth(QueueDepth)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push0_i     (v0),
        .push0_data_i(e0),
        .push1_i     (v1),
        .push1_data_i(e1),
        .pop_i       (instr_ready_i),
        .head_o      (head),
        .empty_o     (empty),
        .free_o      (free)
    );

    assign instr_valid_o = !empty;
    assign instr_pc_o    = head.pc;
    assign instr_o       = head.instr;
    assign is_rv16_o     = head.is_rv16;
    assign fetch_err_o   = head.err;

endmodule

// File: doc/instr_realigner.md
Name: instr_realigner

Overview:
- Fetch-side realignment queue that sits directly upstream of decode and turns 32-bit aligned fetch words into a stream of individual instructions.
- Each output instruction carries its PC, its raw encoding and an is_rv16 flag; the RV16 expander and the decoder consume this stream.
- Handles compressed instructions, 32-bit instructions that straddle fetch words, and entry at a halfword address after a redirect.
- Buffers results so fetch and decode are decoupled by a valid/ready handshake on each side.

Parameters:
QueueDepth, 4, instruction queue entries; power of two, >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  redirect: discard queue and halfword buffer
fetch_valid_i  in  1  fetch word valid
fetch_ready_o  out  1  word accepted when valid & ready
fetch_addr_i  in  32  address of first useful halfword; bit0 = 0; bit1 = 1 means start at upper half
fetch_data_i  in  32  word read from {fetch_addr_i[31:2], 2'b00}
fetch_err_i  in  1  access fault for this word
instr_valid_o  out  1  queue head valid
instr_ready_i  in  1  decode consumes head
instr_pc_o  out  32  PC of head
instr_o  out  32  raw instruction; [31:16] = 0 when compressed
is_rv16_o  out  1  head is compressed (bits[1:0] != 2'b11)
fetch_err_o  out  1  head carries an access fault

Behaviour:
- Reset (async, rst_i = 1): queue empty; halfword buffer invalid; instr_valid_o = 0; all data outputs 0; fetch_ready_o = 1 after release.
- Halfword buffer state: hb_valid, hb_data[15:0], hb_pc[31:0]. It holds the lower half of a 32-bit instruction that crosses a word boundary.
- fetch_ready_o = (free entries >= 2) & ~flush_i. Each accepted word pushes 0, 1 or 2 entries.
- Processing an accepted word; L = data[15:0], U = data[31:16], A = {addr[31:2], 2'b00}:
  - hb_valid: push {L, hb_data} at hb_pc, 32-bit; hb_valid cleared; then process U.
  - ~hb_valid, addr[1] = 0, L[1:0] != 11: push L at A as rv16; then process U.
  - ~hb_valid, addr[1] = 0, L[1:0] == 11: push the full word at A, 32-bit; U is not processed.
  - ~hb_valid, addr[1] = 1: L is ignored; process U.
  - Process U: if U[1:0] != 11, push U at A+2 as rv16. Otherwise set hb_valid, hb_data = U, hb_pc = A+2.
- Contiguity: while hb_valid, the next word is the sequential one (A = hb_pc + 2). Fetch guarantees this unless flush_i is asserted; no check in RTL.
- fetch_err_i on an accepted word:
  - Push exactly one entry with fetch_err_o = 1 and instr = 0.
  - Its PC is hb_pc if hb_valid, otherwise fetch_addr_i.
  - hb_valid is cleared; the rest of the word is discarded.
- Queue ordering: when two entries are pushed in one cycle, the lower-address one is pushed first. Circular FIFO with rd/wr pointers one bit wider than log2(QueueDepth).
- Outputs: head driven directly from queue storage; instr_valid_o = ~empty.
- Latency: a word accepted in cycle N is visible at the head in cycle N+1. No combinational path from fetch inputs to instr outputs, or from instr_ready_i to fetch_ready_o.
- Throughput: 1 pop per cycle. Push and pop in the same cycle are allowed: count_next = count + pushes - pop.
- Full: fetch_ready_o drops once free entries < 2. A pop does not raise fetch_ready_o in the same cycle.
- flush_i:
  - Synchronous; priority over push and pop.
  - Next cycle: queue empty and hb_valid = 0.
  - A fetch word presented during the flush cycle is not accepted (fetch_ready_o = 0).
  - Head outputs are don't-care once instr_valid_o = 0.
- Reset mid-operation: immediate return to the reset state; partially buffered instructions are lost.
- Stability: while instr_valid_o & ~instr_ready_i, all head outputs hold, except on flush or reset.

Decomposition:
- Shared package OoO_pkg gets:
  - fetch_entry_t {pc[31:0], instr[31:0], is_rv16, err}.
  - Constant InstrQueueDepth, used to set QueueDepth.
- One sub-module, instr_queue: a dual-push, single-pop FIFO of fetch_entry_t with flush and a free-count output.
- Realignment logic stays in instr_realigner.

Test Plan:
1. Aligned 32-bit: addr 0x8000_0000, data 0x0000_0513 -> one entry: pc 0x8000_0000, instr 0x0000_0513, is_rv16 = 0, visible the next cycle.
2. Two compressed: addr 0x8000_0004, data 0x4505_4501 -> pc 0x8000_0004 instr 0x0000_4501, then pc 0x8000_0006 instr 0x0000_4505, both rv16.
3. Straddle:
   - Stimulus: addr 0x8000_0008 data 0x0513_4501, then addr 0x8000_000C data 0x4501_0000.
   - Required: pc 0x8000_0008 rv16 0x4501; pc 0x8000_000A instr 0x0000_0513, 32-bit; pc 0x8000_000E rv16 0x4501.
4. Halfword entry: addr 0x8000_0012, data 0x4505_FFFF -> only pc 0x8000_0012 instr 0x0000_4505; low half ignored.
5. Backpressure/flush:
   - Hold instr_ready_i = 0 and stream words until fetch_ready_o = 0; head stays stable.
   - Assert flush_i with hb_valid = 1 -> next cycle instr_valid_o = 0, and the following word at 0x8000_0100 starts clean.
6. Fault: hb_valid with hb_pc 0x8000_001E, next word has fetch_err_i = 1 -> one entry: pc 0x8000_001E, fetch_err_o = 1, instr 0; hb_valid = 0. Also reset mid-stream -> all outputs 0 immediately.
